// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared FSM state type and parameter defaults for pulse_meter.
package pulse_meter_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } state_t;

endpackage

// File: rtl/pulse_meter_sync_edge.sv
// sync_edge: synchronises an async input and flags its rising/falling edges.
//   clk, nreset : clock, synchronous active-low reset
//   sig_in      : asynchronous input
//   level       : synchronised level
//   rise / fall : one-cycle pulses on synchronised edges
module sync_edge
    import pulse_meter_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic nreset,
    input  logic sig_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              hist;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], sig_in};
            hist <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high/low phase durations of an async signal, one result per period.
//   clk, nreset      : clock, synchronous active-low reset
//   en               : measurement enable; low returns the FSM to IDLE
//   sig_in           : asynchronous signal under test
//   m_valid/m_ready  : result handshake
//   m_high / m_low   : high / low phase duration in clk cycles
//   m_ovf            : a counter saturated during this measurement
//   m_drop           : results were discarded before this one
//   busy             : FSM not in IDLE
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic             sig_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_high,
    output logic [CNT_W-1:0] m_low,
    output logic             m_ovf,
    output logic             m_drop,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] hi_cnt, lo_cnt;
    logic             ovf, drop;
    logic             level, rise, fall;
    logic             unused_level;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .nreset (nreset),
        .sig_in (sig_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    // The FSM works purely on edges; the level is not needed here.
    assign unused_level = level;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            hi_cnt  <= '0;
            lo_cnt  <= '0;
            ovf     <= 1'b0;
            drop    <= 1'b0;
            m_valid <= 1'b0;
            m_high  <= '0;
            m_low   <= '0;
            m_ovf   <= 1'b0;
            m_drop  <= 1'b0;
        end else begin
            // Acceptance clears m_valid; a same-cycle commit below overrides it.
            if (m_valid && m_ready)
                m_valid <= 1'b0;
            if (!en) begin
                state  <= IDLE;
                busy   <= 1'b0;
                hi_cnt <= '0;
                lo_cnt <= '0;
                ovf    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                    ARM: if (rise) begin
                        state  <= HIGH;
                        hi_cnt <= CNT_W'(1);
                    end
                    HIGH: if (fall) begin
                        state  <= LOW;
                        lo_cnt <= CNT_W'(1);
                    end else begin
                        hi_cnt <= hi_cnt + CNT_W'(hi_cnt != MAX);
                        if (hi_cnt == MAX)
                            ovf <= 1'b1;
                    end
                    LOW: if (rise) begin
                        // Closing rise ends this period and opens the next one.
                        if (!m_valid || m_ready) begin
                            m_valid <= 1'b1;
                            m_high  <= hi_cnt;
                            m_low   <= lo_cnt;
                            m_ovf   <= ovf;
                            m_drop  <= drop;
                            drop    <= 1'b0;
                        end else begin
                            drop <= 1'b1;
                        end
                        state  <= HIGH;
                        hi_cnt <= CNT_W'(1);
                        lo_cnt <= '0;
                        ovf    <= 1'b0;
                    end else begin
                        lo_cnt <= lo_cnt + CNT_W'(lo_cnt != MAX);
                        if (lo_cnt == MAX)
                            ovf <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: scoreboard bench for pulse_meter (16-bit and 4-bit counter instances).
module tb_pulse_meter;

    typedef struct {
        int h;
        int l;
        bit ovf;
        bit drop;
        bit tol;
        int gap;
    } exp_t;

    logic        clk, nreset, en, sig_in, m_ready;
    logic        m_valid, m_ovf, m_drop, busy;
    logic [15:0] m_high, m_low;
    logic        en4, sig4, m_ready4;
    logic        m_valid4, m_ovf4, m_drop4, busy4;
    logic [3:0]  m_high4, m_low4;

    exp_t q[$], q4[$];
    exp_t e, e4;
    int   checks, passes;
    int   ncyc, last_acc;
    int   ph, pl, want_gap, skip_n;
    bit   have_prev, drop_pend, tol;

    pulse_meter dut (
        .clk(clk), .nreset(nreset), .en(en), .sig_in(sig_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_high(m_high), .m_low(m_low),
        .m_ovf(m_ovf), .m_drop(m_drop), .busy(busy)
    );

    pulse_meter #(.CNT_W(4)) dut4 (
        .clk(clk), .nreset(nreset), .en(en4), .sig_in(sig4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_high(m_high4), .m_low(m_low4),
        .m_ovf(m_ovf4), .m_drop(m_drop4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) ncyc++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passes++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue the just-closed period; skipped entries model results the DUT must drop.
    task automatic push_exp();
        if (skip_n > 0) begin
            skip_n--;
            drop_pend = 1'b1;
        end else begin
            q.push_back('{ph, pl, 1'b0, drop_pend, tol, want_gap});
            drop_pend = 1'b0;
        end
    endtask

    task automatic pulse(input int h, input int l);
        if (have_prev) push_exp();
        sig_in = 1'b1;
        cyc(h);
        sig_in = 1'b0;
        cyc(l);
        ph = h; pl = l; have_prev = 1'b1;
    endtask

    task automatic apulse(input int h, input int l);
        if (have_prev) push_exp();
        sig_in = 1'b1;
        #(h * 10 - 3 + $urandom_range(0, 6));
        sig_in = 1'b0;
        #(l * 10 - 3 + $urandom_range(0, 6));
        ph = h; pl = l; have_prev = 1'b1;
    endtask

    task automatic close_seg();
        if (have_prev) push_exp();
        sig_in = 1'b1;
        cyc(6);
        en = 1'b0;
        sig_in = 1'b0;
        have_prev = 1'b0;
        cyc(4);
    endtask

    always @(negedge clk) begin
        if (nreset && m_valid && m_ready) begin
            check("no_x", int'($isunknown({m_valid, m_high, m_low, m_ovf, m_drop})), 0);
            check("queued", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.tol) begin
                    check("hi_near", int'(int'(m_high) >= e.h - 1 && int'(m_high) <= e.h + 1), 1);
                    check("lo_near", int'(int'(m_low) >= e.l - 1 && int'(m_low) <= e.l + 1), 1);
                end else begin
                    check("hi", m_high, e.h);
                    check("lo", m_low, e.l);
                end
                check("ovf", m_ovf, e.ovf);
                check("drop", m_drop, e.drop);
                if (e.gap != 0) check("period", ncyc - last_acc, e.gap);
            end
            last_acc = ncyc;
        end
    end

    always @(negedge clk) begin
        if (nreset && m_valid4 && m_ready4) begin
            check("queued4", int'(q4.size() > 0), 1);
            if (q4.size() > 0) begin
                e4 = q4.pop_front();
                check("hi4", m_high4, e4.h);
                check("lo4", m_low4, e4.l);
                check("ovf4", m_ovf4, e4.ovf);
                check("drop4", m_drop4, e4.drop);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        nreset = 1'b0; en = 1'b0; sig_in = 1'b0; m_ready = 1'b1;
        en4 = 1'b0; sig4 = 1'b0; m_ready4 = 1'b1;
        cyc(2);
        check("rst_valid", m_valid, 0);
        check("rst_high", m_high, 0);
        check("rst_low", m_low, 0);
        check("rst_ovf", m_ovf, 0);
        check("rst_drop", m_drop, 0);
        check("rst_busy", busy, 0);
        nreset = 1'b1;
        cyc(2);

        // 4-bit counters: 20-cycle high saturates at 15, next period is clean
        en4 = 1'b1;
        cyc(3);
        check("busy4", busy4, 1);
        sig4 = 1'b1; cyc(20);
        sig4 = 1'b0; cyc(3);
        q4.push_back('{15, 3, 1'b1, 1'b0, 1'b0, 0});
        sig4 = 1'b1; cyc(5);
        sig4 = 1'b0; cyc(6);
        q4.push_back('{5, 6, 1'b0, 1'b0, 1'b0, 0});
        sig4 = 1'b1; cyc(6);
        en4 = 1'b0; sig4 = 1'b0;
        cyc(4);

        // periodic 12/12, one result every 24 cycles
        en = 1'b1;
        cyc(3);
        check("busy", busy, 1);
        pulse(12, 12);
        pulse(12, 12);
        want_gap = 24;
        for (int i = 0; i < 3; i++) pulse(12, 12);
        close_seg();
        want_gap = 0;

        // consumer stalls across three commits; two results must be dropped
        m_ready = 1'b0;
        en = 1'b1;
        cyc(3);
        pulse(5, 6);
        pulse(7, 8);
        skip_n = 2;
        pulse(9, 10);
        pulse(11, 12);
        check("hold_valid", m_valid, 1);
        check("hold_high", m_high, 5);
        check("hold_low", m_low, 6);
        check("hold_drop", m_drop, 0);
        m_ready = 1'b1;
        pulse(6, 7);
        close_seg();

        // enable dropped during HIGH: broken period yields nothing
        en = 1'b1;
        cyc(3);
        pulse(10, 10);
        push_exp();
        sig_in = 1'b1;
        cyc(5);
        en = 1'b0; sig_in = 1'b0; have_prev = 1'b0;
        cyc(2);
        check("en_busy", busy, 0);
        cyc(3);
        en = 1'b1;
        cyc(3);
        pulse(7, 9);
        close_seg();

        // reset pulsed during LOW
        en = 1'b1;
        cyc(3);
        pulse(8, 9);
        push_exp();
        sig_in = 1'b1; cyc(8);
        sig_in = 1'b0; cyc(5);
        nreset = 1'b0;
        cyc(1);
        check("mrst_valid", m_valid, 0);
        check("mrst_high", m_high, 0);
        check("mrst_low", m_low, 0);
        check("mrst_ovf", m_ovf, 0);
        check("mrst_drop", m_drop, 0);
        check("mrst_busy", busy, 0);
        nreset = 1'b1;
        have_prev = 1'b0;
        cyc(3);
        pulse(10, 11);
        close_seg();

        // edges at random phase relative to clk
        en = 1'b1;
        cyc(3);
        tol = 1'b1;
        #($urandom_range(0, 9));
        apulse(9, 14);
        apulse(15, 6);
        apulse(11, 11);
        apulse(20, 8);
        close_seg();
        tol = 1'b0;

        for (int n = 0; n < 200 && (q.size() + q4.size()) > 0; n++) @(posedge clk);
        check("drain", q.size() + q4.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
